addv_multiword_seq: RTL
=======================

// Module: addv_multiword_seq
// PURPOSE
//  Sequencer that performs a wide add/subtract (width*words bits) by time-multiplexing one
//  width-bit parallel-prefix adder slice, least-significant word first, carry held in a flop.
//  Sits between an operand producer and a result consumer. Both sides use valid/ready
//  handshakes. Trades area for latency when wide adds are rare.
// PARAMETERS
//  width  8  slice word width in bits; must be >= 2
//  words  4  number of slices per operand; must be >= 1; operand width W = width*words
//  speed  2  prefix architecture of the slice: 0 serial, 1 Brent-Kung, 2 Sklansky
// PORTS
//  CLK       in   1  clock; all state updates on the rising edge
//  RST       in   1  reset; synchronous, active-high
//  InValid   in   1  operands A, B, CI, Sub are valid
//  InReady   out  1  block can accept operands
//  A         in   W  operand A, two's complement
//  B         in   W  operand B, two's complement
//  CI        in   1  carry in; ignored when Sub=1
//  Sub       in   1  0: S=A+B+CI; 1: S=A-B (A + ~B + 1)
//  OutValid  out  1  S and V are valid
//  OutReady  in   1  consumer accepts the result
//  S         out  W  result, modulo 2^W
//  V         out  1  two's-complement overflow of the full W-bit operation
// BEHAVIOUR
//  - Reset: state=IDLE. InReady=1. OutValid=0. S=0. V=0. Word index=0. Carry flop=0.
//  - RST dominates every other input in the same cycle.
//  - FSM states:
//    - IDLE: InReady=1. On InValid&InReady, latch A, B^{W{Sub}} and carry=Sub?1:CI.
//      Clear idx and go to RUN.
//    - RUN: InReady=0. The slice adds word idx of A and Bx with the carry flop.
//      The sum is written to S[idx*width +: width] and carry<=slice CO.
//      If idx==words-1, latch V from the slice and go to DONE; otherwise idx++.
//    - DONE: OutValid=1. S and V are held stable. On OutReady, go to IDLE (OutValid=0 next cycle).
//  - Latency: handshake at edge k. OutValid is first high after edge k+words (words RUN cycles).
//  - Throughput: one operation per words+2 cycles when OutReady=1.
//    The next accept is possible the cycle after DONE exits; no accept overlaps with RUN or DONE.
//  - V reflects only the top slice: V = carry into the MSB ^ carry out of the MSB. Lower slices never touch V.
//  - S is cleared to 0 on accept. Unwritten words stay 0 until RUN completes.
//    S is only meaningful while OutValid=1.
//  - words=1: a single RUN cycle. It must behave identically to a plain width-bit add with V.
//  - idx uses max(1,$clog2(words)) bits and never wraps. Reaching words-1 always leaves RUN.
//  - Input changes while InReady=0 are ignored. The operands latched at accept are used.
//  - RST mid-RUN or mid-DONE discards the operation. The next cycle is IDLE with outputs at reset values.
//  - OutReady held low: stays in DONE indefinitely with S/V stable. InReady stays 0.
// STRUCTURE
//  - Package addv_pkg holds:
//    - typedef enum logic [1:0] {IDLE, RUN, DONE} addv_seq_state_e
//    - function for the idx width.
//  - One sub-module, addcv_slice #(width, speed):
//    - ports A, B, CI, S, CO, V.
//    - uses the PrefixAndOr generate/propagate network; CO=GO[width-1], V=GO[width-1]^GO[width-2].
//  - The FSM, idx counter, carry flop and operand/result registers live in the top level. No other sub-modules.
// TESTING  (width=8, words=4, speed=2 unless stated)
//  1. Carry ripple: A=32'hFFFFFFFF, B=0, CI=1, Sub=0.
//     Expect S=32'h00000000, V=0, OutValid high exactly 4 cycles after the accept edge.
//  2. Positive overflow: A=32'h7FFFFFFF, B=32'h00000001, CI=0.
//     Expect S=32'h80000000, V=1.
//  3. Subtract with overflow: A=32'h80000000, B=32'h00000001, Sub=1, CI=1 (ignored).
//     Expect S=32'h7FFFFFFF, V=1. Then A=5, B=7, Sub=1: expect S=32'hFFFFFFFE, V=0.
//  4. Backpressure: OutReady=0 for 6 cycles after OutValid.
//     S/V must stay constant, InReady=0, and new InValid is ignored. OutReady=1 gives IDLE next cycle.
//  5. Reset mid-RUN: assert RST on the 2nd RUN cycle.
//     Next cycle: OutValid=0, InReady=1, S=0, V=0. A following add of 1+1 returns S=2.
//  6. Sweep: words=1 and speed in {0,1,2}, random A/B/CI/Sub.
//     S and V must match a behavioural W-bit model over 10k operations with random OutReady.

Source files
------------

// File: rtl/addv_pkg.sv
// Shared types and helpers for the multi-word add/subtract sequencer.
package addv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } addv_seq_state_e;

  // Prefix architecture selectors for the adder slice.
  localparam int SPEED_SERIAL     = 0;
  localparam int SPEED_BRENT_KUNG = 1;
  localparam int SPEED_SKLANSKY   = 2;

  // The word index needs at least one bit, even when there is only one word.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/addv_multiword_seq_if.sv
// Producer/consumer handshake bundle for the multi-word add/subtract sequencer.
interface addv_multiword_seq_if #(
  parameter int width = 8,
  parameter int words = 4
);
  localparam int W = width * words;

  logic         InValid;
  logic         InReady;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CI;
  logic         Sub;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] S;
  logic         V;

  // Producer/consumer side.
  modport master (
    output InValid, A, B, CI, Sub, OutReady,
    input  InReady, OutValid, S, V
  );

  // Sequencer side.
  modport slave (
    input  InValid, A, B, CI, Sub, OutReady,
    output InReady, OutValid, S, V
  );
endinterface

// File: rtl/addcv_slice.sv
// One width-bit adder slice built on a generate/propagate prefix network.
// The carry-in is folded into bit 0, so go[i] is the carry out of bit i.
module addcv_slice
  import addv_pkg::*;
#(
  parameter int width = 8,
  parameter int speed = SPEED_SKLANSKY
) (
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             CI,
  output logic [width-1:0] S,
  output logic             CO,
  output logic             V
);

  localparam int levels = $clog2(width);

  logic [width-1:0] p_bit;
  logic [width-1:0] go;
  logic [width-1:0] gp;

  // Prefix network (PrefixAndOr): group generate/propagate, updated in place level by level.
  always_comb begin
    int j;
    // NOTE: every variable gets a value up front so no path through this block can infer a latch.
    j     = 0;
    p_bit = A ^ B;
    go    = A & B;
    go[0] = go[0] | (p_bit[0] & CI);
    gp    = p_bit;
    case (speed)
      SPEED_SERIAL: begin
        for (int i = 1; i < width; i++) begin
          go[i] = go[i] | (gp[i] & go[i-1]);
          gp[i] = gp[i] & gp[i-1];
        end
      end
      SPEED_BRENT_KUNG: begin
        // Up-sweep builds power-of-two spans; down-sweep fills the remaining positions.
        for (int l = 0; l < levels; l++) begin
          for (int i = 0; i < width; i++) begin
            if (((i + 1) % (1 << (l + 1))) == 0) begin
              j     = i - (1 << l);
              go[i] = go[i] | (gp[i] & go[j]);
              gp[i] = gp[i] & gp[j];
            end
          end
        end
        for (int l = levels - 1; l >= 0; l--) begin
          for (int i = 0; i < width; i++) begin
            if ((((i + 1) % (1 << (l + 1))) == (1 << l)) && (i > (1 << l))) begin
              j     = i - (1 << l);
              go[i] = go[i] | (gp[i] & go[j]);
              gp[i] = gp[i] & gp[j];
            end
          end
        end
      end
      default: begin
        // Sklansky: each upper half-block takes the last prefix of the lower half.
        for (int l = 0; l < levels; l++) begin
          for (int i = 0; i < width; i++) begin
            if (((i >> l) & 1) == 1) begin
              j     = ((i >> l) << l) - 1;
              go[i] = go[i] | (gp[i] & go[j]);
              gp[i] = gp[i] & gp[j];
            end
          end
        end
      end
    endcase
  end

  assign S  = p_bit ^ {go[width-2:0], CI};
  assign CO = go[width-1];
  assign V  = go[width-1] ^ go[width-2];

endmodule

// File: rtl/addv_multiword_seq.sv
// Wide add/subtract sequencer: one slice reused LS word first, carry held in a flop.
module addv_multiword_seq
  import addv_pkg::*;
#(
  parameter int width = 8,
  parameter int words = 4,
  parameter int speed = SPEED_SKLANSKY
) (
  input  logic                CLK,
  input  logic                RST,
  addv_multiword_seq_if.slave bus
);

  localparam int W     = width * words;
  localparam int idx_w = idx_width(words);
  localparam logic [idx_w-1:0] last_idx = idx_w'(words - 1);

  addv_seq_state_e  state;
  logic [idx_w-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_q;
  logic [W-1:0]     bx_q;
  logic [W-1:0]     s_q;
  logic             v_q;
  logic             in_ready;
  logic             out_valid;

  logic [width-1:0] slice_s;
  logic             slice_co;
  logic             slice_v;

  addcv_slice #(
    .width (width),
    .speed (speed)
  ) u_slice (
    .A  (a_q[idx*width +: width]),
    .B  (bx_q[idx*width +: width]),
    .CI (carry),
    .S  (slice_s),
    .CO (slice_co),
    .V  (slice_v)
  );

  // Sequencer FSM with word index, carry flop, operand and result registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: operand registers are reset too; it costs little and keeps the slice inputs defined.
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      bx_q      <= '0;
      s_q       <= '0;
      v_q       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.InValid) begin
            a_q      <= bus.A;
            bx_q     <= bus.B ^ {W{bus.Sub}};
            carry    <= bus.Sub ? 1'b1 : bus.CI;
            idx      <= '0;
            s_q      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          s_q[idx*width +: width] <= slice_s;
          carry                   <= slice_co;
          if (idx == last_idx) begin
            v_q       <= slice_v;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.OutReady) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.OutValid = out_valid;
  assign bus.S        = s_q;
  assign bus.V        = v_q;

endmodule
